// File: rtl/mmcm_drp_pkg.sv
// Shared types and per-mode DRP register table for the pixel-clock MMCM reconfigurator.
package mmcm_drp_pkg;

  localparam int unsigned DRP_ADDR_W = 7;
  localparam int unsigned DRP_DATA_W = 16;
  localparam int unsigned MODE_W     = 3;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned N_TBL      = 23;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    LOAD,
    RD,
    WAITRD,
    WR,
    WAITWR,
    LOCKWAIT
  } state_t;

  typedef struct packed {
    logic [DRP_ADDR_W-1:0] addr;
    logic [DRP_DATA_W-1:0] mask;
    logic [DRP_DATA_W-1:0] data;
  } drp_entry_t;

  localparam logic [DRP_ADDR_W-1:0] ADDR_TBL [N_TBL] = '{
    7'h28, 7'h08, 7'h09, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0E,
    7'h0F, 7'h10, 7'h11, 7'h06, 7'h07, 7'h12, 7'h13, 7'h16,
    7'h14, 7'h15, 7'h18, 7'h19, 7'h1A, 7'h4E, 7'h4F
  };

  // Mask bits set to 1 are preserved from the register's current contents.
  localparam logic [DRP_DATA_W-1:0] MASK_TBL [N_TBL] = '{
    16'h1000, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000,
    16'hFC00, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'h1000, 16'hFC00, 16'hC000,
    16'h1000, 16'hFC00, 16'hFC00, 16'h8000, 16'h8000, 16'h66FF, 16'h666F
  };

  localparam logic [DRP_DATA_W-1:0] DATA_BASE [N_TBL] = '{
    16'h0081, 16'h0041, 16'h0000, 16'h0083, 16'h0040, 16'h0145, 16'h0080, 16'h0209,
    16'h0041, 16'h0000, 16'h00C3, 16'h0041, 16'h0000, 16'h0104, 16'h0080, 16'h1041,
    16'h0208, 16'h0000, 16'h01E8, 16'h7001, 16'h73E9, 16'h0800, 16'h1100
  };

  // Modes differ by an XOR of the mode index into bits [8:6]; preserved bits are never driven.
  function automatic drp_entry_t rom_entry(input logic [MODE_W-1:0] mode,
                                           input logic [IDX_W-1:0]  idx);
    drp_entry_t e;
    e = '0;
    if (idx < IDX_W'(N_TBL)) begin
      e.addr = ADDR_TBL[idx];
      e.mask = MASK_TBL[idx];
      e.data = (DATA_BASE[idx] ^ (16'(mode) << 6)) & ~MASK_TBL[idx];
    end
    return e;
  endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_rom.sv
// Registered (mode, idx) -> {addr, mask, data} lookup with one cycle of latency.
module mmcm_mode_rom
  import mmcm_drp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] mode,
  input  logic [IDX_W-1:0]  idx,
  output drp_entry_t        entry
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry <= '0;
    else     entry <= rom_entry(mode, idx);
  end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCM DRP reconfiguration sequencer: per-register read-modify-write while MMCM is held in reset.
// Optional wait timeout enabled by defining MMCM_DRP_TIMEOUT_EN.
module mmcm_drp_reconfig
  import mmcm_drp_pkg::*;
#(
  parameter int unsigned N_REGS       = 23,
  parameter int unsigned LOCK_HOLDOFF = 16
`ifdef MMCM_DRP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sen,
  input  logic [MODE_W-1:0]     video_mode,
  input  logic                  locked,
  output logic                  rst_mmcm,
  output logic [DRP_ADDR_W-1:0] daddr,
  output logic [DRP_DATA_W-1:0] di,
  output logic                  den,
  output logic                  dwe,
  input  logic [DRP_DATA_W-1:0] dout,
  input  logic                  drdy,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned HO_W = (LOCK_HOLDOFF > 0) ? $clog2(LOCK_HOLDOFF + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  state_t                state, state_next;
  logic [IDX_W-1:0]      idx;
  logic [MODE_W-1:0]     target;
  logic                  pending;
  logic [DRP_DATA_W-1:0] rd_data;
  logic [HO_W-1:0]       holdoff;
  logic                  lock_ok;
  logic                  timeout;
  drp_entry_t            rom_q;

  mmcm_mode_rom u_rom (
    .clk   (clk),
    .rst   (rst),
    .mode  (target),
    .idx   (idx),
    .entry (rom_q)
  );

  assign lock_ok = (state == LOCKWAIT) && (holdoff == '0) && locked;

`ifdef MMCM_DRP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_run;
  logic             err_q;

  assign tmo_run = (state == WAITRD) || (state == WAITWR) ||
                   ((state == LOCKWAIT) && (holdoff == '0));
  assign timeout = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (tmo_run && !timeout) ? tmo_cnt + 1'b1 : '0;
      err_q   <= err_q | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (pending) state_next = RST;
      RST:      state_next = LOAD;
      LOAD:     state_next = RD;
      RD:       state_next = WAITRD;
      WAITRD:   if (drdy) state_next = WR;
      WR:       state_next = WAITWR;
      WAITWR:   if (drdy) state_next = (idx == LAST_IDX) ? LOCKWAIT : LOAD;
      LOCKWAIT: if (lock_ok) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      target   <= '0;
      pending  <= 1'b1;
      rd_data  <= '0;
      holdoff  <= '0;
      rst_mmcm <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_next;
      done    <= 1'b0;
      // A request arriving in the same cycle as the IDLE launch keeps pending set.
      pending <= sen | (pending & (state != IDLE));
      case (state)
        IDLE: if (pending) begin
          target <= video_mode;
          idx    <= '0;
        end
        RST: begin
          rst_mmcm <= 1'b1;
          busy     <= 1'b1;
        end
        WAITRD: if (drdy) rd_data <= dout;
        WAITWR: if (drdy && (idx != LAST_IDX)) idx <= idx + 1'b1;
        LOCKWAIT: begin
          if (holdoff != '0) holdoff <= holdoff - 1'b1;
          else if (lock_ok && !timeout) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
      if ((state_next == LOCKWAIT) && (state != LOCKWAIT)) begin
        rst_mmcm <= 1'b0;
        holdoff  <= HO_W'(LOCK_HOLDOFF);
      end
      if (timeout) begin
        rst_mmcm <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

  always_comb begin
    den   = 1'b0;
    dwe   = 1'b0;
    daddr = '0;
    di    = '0;
    if (state == RD) begin
      den   = 1'b1;
      daddr = rom_q.addr;
    end else if (state == WR) begin
      den   = 1'b1;
      dwe   = 1'b1;
      daddr = rom_q.addr;
      di    = (rd_data & rom_q.mask) | rom_q.data;
    end
  end

endmodule
